// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader: FSM states, widths,
// default frame marker and program memory depth.
package loader_pkg;

   localparam int unsigned BYTE_W         = 8;
   localparam int unsigned WORD_W         = 32;
   localparam int unsigned ADDR_W         = 8;
   localparam int unsigned BYTES_PER_WORD = 4;
   localparam int unsigned PROG_DEPTH     = 256;

   localparam logic [BYTE_W-1:0] DEFAULT_SYNC_BYTE = 8'hA5;

   typedef enum logic [1:0] {IDLE, COUNT, DATA, CHECK} state_t;

endpackage

// File: rtl/word_assembler.sv
// Shifts incoming bytes MSB first into a 32-bit word and flags the byte
// that completes it; the completed word is presented combinationally.
module word_assembler
   import loader_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              byte_valid,
   input  logic [BYTE_W-1:0] byte_data,
   output logic [WORD_W-1:0] word_data,
   output logic              word_done
);

   logic [WORD_W-BYTE_W-1:0] sreg;
   logic [1:0]               idx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sreg <= '0;
         idx  <= '0;
      end else if (clear) begin
         sreg <= '0;
         idx  <= '0;
      end else if (byte_valid) begin
         sreg <= {sreg[WORD_W-2*BYTE_W-1:0], byte_data};
         idx  <= idx + 2'd1;
      end
   end

   // Only the three earlier bytes are stored; the fourth is spliced in live.
   assign word_data = {sreg, byte_data};
   assign word_done = byte_valid && (idx == 2'd3);

endmodule

// File: rtl/program_loader.sv
// Frames a byte stream (SYNC, COUNT, 4*N data bytes, CHK) into program
// memory writes and holds the CPU in reset until a checksum-valid load.
module program_loader
   import loader_pkg::*;
#(
   parameter logic [BYTE_W-1:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE,
   parameter int unsigned       TIMEOUT_CYCLES = 1_000_000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rx_valid,
   input  logic [BYTE_W-1:0] rx_data,
   output logic              prog_write,
   output logic [ADDR_W-1:0] prog_addr,
   output logic [WORD_W-1:0] prog_data,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic              cpu_hold
);

   localparam logic [23:0] TMO_LAST = 24'(TIMEOUT_CYCLES - 1);

   state_t            state;
   logic [ADDR_W-1:0] wr_addr;
   logic [ADDR_W:0]   n_words;
   logic [ADDR_W:0]   word_cnt;
   logic [BYTE_W-1:0] sum;
   logic [23:0]       timer;

   logic              asm_valid;
   logic [WORD_W-1:0] asm_word;
   logic              asm_done;

   assign asm_valid = rx_valid && (state == DATA);

   word_assembler u_word_assembler (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (state == IDLE),
      .byte_valid (asm_valid),
      .byte_data  (rx_data),
      .word_data  (asm_word),
      .word_done  (asm_done)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         prog_write <= 1'b0;
         prog_addr  <= '0;
         prog_data  <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
         cpu_hold   <= 1'b1;
         wr_addr    <= '0;
         n_words    <= '0;
         word_cnt   <= '0;
         sum        <= '0;
         timer      <= '0;
      end else begin
         prog_write <= 1'b0;
         done       <= 1'b0;

         if (state == IDLE || rx_valid)
            timer <= '0;
         else
            timer <= timer + 24'd1;

         if (state != IDLE && !rx_valid && timer == TMO_LAST) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b1;
            error    <= 1'b1;
            cpu_hold <= 1'b1;
         end else if (rx_valid) begin
            unique case (state)
               IDLE: begin
                  if (rx_data == SYNC_BYTE) begin
                     state    <= COUNT;
                     busy     <= 1'b1;
                     error    <= 1'b0;
                     cpu_hold <= 1'b1;
                     wr_addr  <= '0;
                     word_cnt <= '0;
                     sum      <= '0;
                  end
               end
               COUNT: begin
                  n_words <= (rx_data == '0) ? (ADDR_W+1)'(PROG_DEPTH)
                                             : {1'b0, rx_data};
                  state   <= DATA;
               end
               DATA: begin
                  sum <= sum + rx_data;
                  if (asm_done) begin
                     prog_write <= 1'b1;
                     prog_addr  <= wr_addr;
                     prog_data  <= asm_word;
                     wr_addr    <= wr_addr + 1'b1;
                     word_cnt   <= word_cnt + 1'b1;
                     // 9-bit count so a 256-word image terminates despite address wrap.
                     if (word_cnt + 1'b1 == n_words)
                        state <= CHECK;
                  end
               end
               CHECK: begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  if (rx_data == sum)
                     cpu_hold <= 1'b0;
                  else
                     error <= 1'b1;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected writes and frame results are
// queued as frames are driven and popped as the DUT produces them.
module tb_program_loader;

   localparam int unsigned TMO = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_data = '0;
   logic        prog_write;
   logic [7:0]  prog_addr;
   logic [31:0] prog_data;
   logic        busy;
   logic        done;
   logic        error;
   logic        cpu_hold;

   int unsigned total = 0;
   int unsigned bad   = 0;

   logic [39:0] wr_q[$];    // {addr, data}
   logic [1:0]  done_q[$];  // {error, cpu_hold}
   logic [31:0] img[256];

   program_loader #(.SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TMO)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx_valid   (rx_valid),
      .rx_data    (rx_data),
      .prog_write (prog_write),
      .prog_addr  (prog_addr),
      .prog_data  (prog_data),
      .busy       (busy),
      .done       (done),
      .error      (error),
      .cpu_hold   (cpu_hold)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && prog_write) begin
         if (wr_q.size() == 0) begin
            check("extra_write", 64'(prog_addr), 64'hFFFF);
         end else begin
            logic [39:0] e;
            e = wr_q.pop_front();
            check("wr_addr", 64'(prog_addr), 64'(e[39:32]));
            check("wr_data", 64'(prog_data), 64'(e[31:0]));
         end
         check("wr_done_overlap", 64'(done), 64'd0);
      end
      if (rst_n && done) begin
         if (done_q.size() == 0) begin
            check("extra_done", 64'(done), 64'd0);
         end else begin
            logic [1:0] d;
            d = done_q.pop_front();
            check("done_error", 64'(error), 64'(d[1]));
            check("done_hold", 64'(cpu_hold), 64'(d[0]));
            check("done_busy", 64'(busy), 64'd0);
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = b;
      @(posedge clk);
      #1 rx_valid = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      bit seen = 1'b0;
      for (int i = 0; i < 64; i++) begin
         if (done) begin
            seen = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      check(tag, 64'(seen), 64'd1);
      @(posedge clk); #1;
   endtask

   // Sends a full frame of n words from img[]; chk_delta != 0 corrupts CHK.
   task automatic load_frame(input int n, input logic [7:0] chk_delta);
      logic [7:0] sum = '0;
      logic [31:0] w;
      for (int k = 0; k < n; k++) begin
         w = img[k];
         sum = sum + w[31:24] + w[23:16] + w[15:8] + w[7:0];
         wr_q.push_back({8'(k), w});
      end
      done_q.push_back({chk_delta != 0, chk_delta != 0});
      send_byte(8'hA5);
      send_byte(8'(n));
      for (int k = 0; k < n; k++) begin
         w = img[k];
         for (int b = 3; b >= 0; b--) send_byte(w[8*b +: 8]);
      end
      send_byte(sum + chk_delta);
   endtask

   initial begin
      #12;
      check("rst_write", 64'(prog_write), 64'd0);
      check("rst_addr", 64'(prog_addr), 64'd0);
      check("rst_data", 64'(prog_data), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_error", 64'(error), 64'd0);
      check("rst_hold", 64'(cpu_hold), 64'd1);
      @(negedge clk); rst_n = 1'b1;

      // Two words, good checksum, back to back
      img[0] = 32'h01020304;
      img[1] = 32'hA0B0C0D0;
      load_frame(2, 8'd0);
      wait_done("done_good2");
      check("hold_after_good", 64'(cpu_hold), 64'd0);

      // Same frame, bad checksum
      load_frame(2, 8'd1);
      wait_done("done_bad2");
      check("err_after_bad", 64'(error), 64'd1);

      // COUNT=0 means 256 words
      for (int k = 0; k < 256; k++) img[k] = {4{8'(k)}};
      load_frame(256, 8'd0);
      wait_done("done_256");
      check("err_after_256", 64'(error), 64'd0);

      // Timeout after 5 data bytes: one write, done after TMO idle cycles
      wr_q.push_back({8'd0, 32'h11223344});
      done_q.push_back(2'b11);
      send_byte(8'hA5);
      send_byte(8'd2);
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
      send_byte(8'h55);
      check("busy_mid_frame", 64'(busy), 64'd1);
      begin
         int at = 0;
         for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (done) begin
               at = i;
               break;
            end
         end
         check("timeout_cycle", 64'(at), 64'(TMO));
      end
      @(posedge clk); #1;
      check("err_after_tmo", 64'(error), 64'd1);

      // Junk before SYNC, then a frame with A5 as data
      send_byte(8'h00);
      send_byte(8'hFF);
      check("junk_busy", 64'(busy), 64'd0);
      img[0] = 32'hA5A50102;
      img[1] = 32'h0304A5FF;
      img[2] = 32'hDEADBEEF;
      load_frame(3, 8'd0);
      wait_done("done_a5");
      check("err_cleared", 64'(error), 64'd0);
      check("hold_cleared", 64'(cpu_hold), 64'd0);

      // Reset mid-frame after 6 data bytes
      wr_q.push_back({8'd0, 32'hCAFEF00D});
      send_byte(8'hA5);
      send_byte(8'd3);
      send_byte(8'hCA); send_byte(8'hFE); send_byte(8'hF0); send_byte(8'h0D);
      send_byte(8'h12); send_byte(8'h34);
      @(negedge clk); rst_n = 1'b0;
      #1;
      check("mr_write", 64'(prog_write), 64'd0);
      check("mr_addr", 64'(prog_addr), 64'd0);
      check("mr_data", 64'(prog_data), 64'd0);
      check("mr_busy", 64'(busy), 64'd0);
      check("mr_error", 64'(error), 64'd0);
      check("mr_hold", 64'(cpu_hold), 64'd1);
      repeat (3) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1 check("post_rst_write", 64'(prog_write), 64'd0);
      img[0] = 32'h0BADC0DE;
      load_frame(1, 8'd0);
      wait_done("done_post_rst");
      check("hold_post_rst", 64'(cpu_hold), 64'd0);

      repeat (4) @(posedge clk);
      check("wr_q_empty", 64'(wr_q.size()), 64'd0);
      check("done_q_empty", 64'(done_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
